// File: rtl/ncl_sync_tx_bridge.sv
// Clocked valid/ready stream to dual-rail NCL wavefront bridge.
// Optional watchdog enabled by defining NCL_TIMEOUT_EN.
module ncl_sync_tx_bridge #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic [WIDTH-1:0]       y_t,
  output logic [WIDTH-1:0]       y_f,
  input  logic                   ki,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   err
);

  localparam int AW = $clog2(DEPTH);

  if (WIDTH < 1) begin : g_bad_width
    $error("WIDTH must be >= 1");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_NULL
  } state_t;

  state_t                 r_state;
  logic [WIDTH-1:0]       r_mem [DEPTH];
  logic [AW:0]            r_wptr;
  logic [AW:0]            r_rptr;
  logic [SYNC_STAGES-1:0] r_ki_sync;

  logic             w_ki_s;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_start;
  logic             w_done;
  logic [WIDTH-1:0] w_head;

  assign w_ki_s  = r_ki_sync[SYNC_STAGES-1];
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push  = in_valid & ~w_full;
  assign w_head  = r_mem[r_rptr[AW-1:0]];
  assign w_start = (r_state == S_IDLE) & ~w_empty & w_ki_s;
  assign w_pop   = (r_state == S_DATA) & ~w_ki_s;
  assign w_done  = (r_state == S_NULL) & w_ki_s;

  assign in_ready   = ~w_full;
  assign fifo_count = r_wptr - r_rptr;
  assign busy       = (r_state != S_IDLE) | ~w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ki_sync <= '0;
    end else begin
      r_ki_sync <= {r_ki_sync[SYNC_STAGES-2:0], ki};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
    end else if (w_push) begin
      r_wptr <= r_wptr + (AW+1)'(1);
    end
  end

  // Rails only ever move NULL->DATA or DATA->NULL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      y_t     <= '0;
      y_f     <= '0;
      r_rptr  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            y_t     <= w_head;
            y_f     <= ~w_head;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_pop) begin
            y_t     <= '0;
            y_f     <= '0;
            r_rptr  <= r_rptr + (AW+1)'(1);
            r_state <= S_NULL;
          end
        end
        S_NULL: begin
          if (w_done) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef NCL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_wd_cnt;
  logic          r_err;
  logic          w_chg;
  logic          w_wait;

  assign w_chg  = w_start | w_pop | w_done;
  assign w_wait = (r_state == S_DATA) | (r_state == S_NULL);
  assign err    = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd_cnt <= '0;
      r_err    <= 1'b0;
    end else if (w_chg) begin
      r_wd_cnt <= '0;
    end else if (w_wait && r_wd_cnt != TW'(TIMEOUT)) begin
      r_wd_cnt <= r_wd_cnt + TW'(1);
      if (r_wd_cnt == TW'(TIMEOUT - 1)) begin
        r_err <= 1'b1;
      end
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
